// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and helpers: key-size modes, per-mode word counts,
// FSM state encoding and the GF(2^8) doubling used for round constants.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_EXPAND = 2'b10,
        ST_DONE   = 2'b11
    } ks_state_t;

    localparam int MAX_SCHED_WORDS = 60;

    function automatic logic [5:0] nk_of(input aes_mode_t mode);
        case (mode)
            AES192:  nk_of = 6'd6;
            AES256:  nk_of = 6'd8;
            default: nk_of = 6'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_t mode);
        case (mode)
            AES192:  nr_of = 4'd12;
            AES256:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] total_words_of(input aes_mode_t mode);
        case (mode)
            AES192:  total_words_of = 6'd52;
            AES256:  total_words_of = 6'd60;
            default: total_words_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel AES S-box lookups; each S-box is computed as the GF(2^8)
// multiplicative inverse (x^254) followed by the affine transform.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        gf_mul = p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte-wise substitution of the whole word.
    always_comb begin
        word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                  sbox(word_i[15:8]),  sbox(word_i[7:0])};
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Multi-slot sequential AES-128/192/256 key expansion: one schedule word per cycle
// into a per-slot word array, with a registered round-key read port.
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter  int NUM_SLOTS = 2,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [1:0]           start_mode,
    input  logic [SLOT_W-1:0]    start_slot,
    input  logic [255:0]         start_key,
    output logic                 busy,
    output logic                 done,
    output logic [SLOT_W-1:0]    done_slot,
    output logic                 cfg_err,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 rd_en,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           rd_round,
    output logic [127:0]         rd_key,
    output logic                 rd_valid
);

    localparam logic [SLOT_W:0] NUM_SLOTS_W = NUM_SLOTS[SLOT_W:0];

    ks_state_t            state_q, state_d;
    aes_mode_t            mode_q, mode_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [255:0]         key_q, key_d;
    logic [5:0]           idx_q, idx_d;
    logic [7:0]           rcon_q, rcon_d;
    logic [2:0]           nk_cnt_q, nk_cnt_d;
    logic                 start_ready_q, start_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SLOT_W-1:0]    done_slot_q, done_slot_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
    logic [127:0]         rd_key_q, rd_key_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [31:0]          sched_q [NUM_SLOTS][MAX_SCHED_WORDS];
    aes_mode_t            slot_mode_q [NUM_SLOTS];

    logic [5:0]           nk_s, total_s;
    logic [31:0]          w_prev_s, w_back_s, sub_in_s, sub_out_s, temp_s, w_new_s;
    logic                 start_legal_s;

    aes_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Next schedule word from w[i-1] and w[i-Nk] of the slot being expanded.
    always_comb begin
        nk_s     = nk_of(mode_q);
        total_s  = total_words_of(mode_q);
        w_prev_s = sched_q[slot_q][idx_q - 6'd1];
        w_back_s = sched_q[slot_q][idx_q - nk_s];
        if (nk_cnt_q == 3'd0) begin
            sub_in_s = {w_prev_s[23:0], w_prev_s[31:24]};
            temp_s   = sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((nk_s == 6'd8) && (nk_cnt_q == 3'd4)) begin
            sub_in_s = w_prev_s;
            temp_s   = sub_out_s;
        end else begin
            sub_in_s = w_prev_s;
            temp_s   = w_prev_s;
        end
        w_new_s = w_back_s ^ temp_s;
    end

    // Expansion FSM next-state and registered-output next values.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        slot_d        = slot_q;
        key_d         = key_q;
        idx_d         = idx_q;
        rcon_d        = rcon_q;
        nk_cnt_d      = nk_cnt_q;
        done_d        = 1'b0;
        done_slot_d   = done_slot_q;
        cfg_err_d     = 1'b0;
        slot_valid_d  = slot_valid_q;
        start_legal_s = (start_mode != 2'b11) && ({1'b0, start_slot} < NUM_SLOTS_W);

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    if (start_legal_s) begin
                        mode_d                   = aes_mode_t'(start_mode);
                        slot_d                   = start_slot;
                        key_d                    = start_key;
                        slot_valid_d[start_slot] = 1'b0;
                        state_d                  = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_d    = nk_s;
                rcon_d   = 8'h01;
                nk_cnt_d = 3'd0;
                state_d  = ST_EXPAND;
            end
            ST_EXPAND: begin
                idx_d = idx_q + 6'd1;
                // For Nk=8 nk_s[2:0] is 0, so 0-1 wraps to 7 as required.
                if (nk_cnt_q == (nk_s[2:0] - 3'd1)) begin
                    nk_cnt_d = 3'd0;
                end else begin
                    nk_cnt_d = nk_cnt_q + 3'd1;
                end
                if (nk_cnt_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (idx_q == (total_s - 6'd1)) begin
                    state_d              = ST_DONE;
                    done_d               = 1'b1;
                    done_slot_d          = slot_q;
                    slot_valid_d[slot_q] = 1'b1;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d == ST_LOAD) || (state_d == ST_EXPAND);
    end

    // Read port: round key of a valid slot whose mode covers the requested round.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_key_d   = 128'h0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (rd_en && (rd_slot == SLOT_W'(s)) && slot_valid_q[SLOT_W'(s)]
                && (rd_round <= nr_of(slot_mode_q[SLOT_W'(s)]))) begin
                rd_valid_d = 1'b1;
                rd_key_d   = {sched_q[SLOT_W'(s)][{rd_round, 2'b00}],
                              sched_q[SLOT_W'(s)][{rd_round, 2'b00} + 6'd1],
                              sched_q[SLOT_W'(s)][{rd_round, 2'b00} + 6'd2],
                              sched_q[SLOT_W'(s)][{rd_round, 2'b00} + 6'd3]};
            end else begin
                rd_valid_d = rd_valid_d;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= AES128;
            slot_q        <= '0;
            key_q         <= 256'h0;
            idx_q         <= 6'd0;
            rcon_q        <= 8'h01;
            nk_cnt_q      <= 3'd0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_slot_q   <= '0;
            cfg_err_q     <= 1'b0;
            slot_valid_q  <= '0;
            rd_key_q      <= 128'h0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            slot_q        <= slot_d;
            key_q         <= key_d;
            idx_q         <= idx_d;
            rcon_q        <= rcon_d;
            nk_cnt_q      <= nk_cnt_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            done_slot_q   <= done_slot_d;
            cfg_err_q     <= cfg_err_d;
            slot_valid_q  <= slot_valid_d;
            rd_key_q      <= rd_key_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Schedule storage is deliberately not reset; slot_valid guards its use.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            // All eight key words are written; unused ones are overwritten by expansion.
            for (int k = 0; k < 8; k++) begin
                sched_q[slot_q][6'(k)] <= key_q[255 - 32*k -: 32];
            end
            slot_mode_q[slot_q] <= mode_q;
        end else if (state_q == ST_EXPAND) begin
            sched_q[slot_q][idx_q] <= w_new_s;
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_slot   = done_slot_q;
    assign cfg_err     = cfg_err_q;
    assign slot_valid  = slot_valid_q;
    assign rd_key      = rd_key_q;
    assign rd_valid    = rd_valid_q;

endmodule
